entry_dispatcher: RTL and testbench

Front-end stage that sits directly upstream of the recurrence datapath and its controller. It buffers incoming entry requests in a small FIFO, issues each one to the engine with a one-cycle load pulse and a completion guard window, and waits for `done`. It then captures the 8-bit result and presents it downstream through a valid/ready handshake, with a watchdog timeout for hung jobs.

---
 rtl/recur_pkg.sv | 18 +
 rtl/entry_dispatcher_if.sv | 26 ++
 rtl/entry_fifo.sv | 48 ++++
 rtl/entry_dispatcher.sv | 141 ++++++++++++++
 tb/tb_entry_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/recur_pkg.sv
// Shared types and helpers for the recurrence front end (dispatcher state, widths).
package recur_pkg;

    localparam int unsigned SIZE_DEFAULT = 4;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_LAUNCH,
        DS_GUARD,
        DS_WAIT,
        DS_OUT
    } ds_state_e;

    function automatic int unsigned result_width(input int unsigned size);
        return 2 * size;
    endfunction

endpackage

// File: rtl/entry_dispatcher_if.sv
// Request and result streams of the entry dispatcher (valid/ready on both sides).
interface entry_dispatcher_if #(
    parameter int unsigned SIZE = recur_pkg::SIZE_DEFAULT
);
    localparam int unsigned RW = recur_pkg::result_width(SIZE);

    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_entry;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_entry;
    logic [RW-1:0]   out_result;
    logic            out_err;

    modport master (
        output in_valid, in_entry, out_ready,
        input  in_ready, out_valid, out_entry, out_result, out_err
    );

    modport slave (
        input  in_valid, in_entry, out_ready,
        output in_ready, out_valid, out_entry, out_result, out_err
    );

endinterface

// File: rtl/entry_fifo.sv
// Parameterised synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module entry_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/entry_dispatcher.sv
// Entry dispatcher: FIFO-buffered job issue to the recurrence engine with watchdog timeout.
// Optional ENTRY_DISPATCHER_BYPASS_EN: entries < 2 skip the engine and return result 1.
module entry_dispatcher
    import recur_pkg::*;
#(
    parameter int unsigned SIZE    = SIZE_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    entry_dispatcher_if.slave             io,
    output logic                          eng_load,
    output logic [SIZE-1:0]               eng_entry,
    output logic                          eng_mask,
    input  logic                          eng_done,
    input  logic [result_width(SIZE)-1:0] eng_result,
    output logic                          busy
);
    localparam int unsigned RW  = result_width(SIZE);
    localparam int unsigned WDW = $clog2(TIMEOUT) + 1;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;

    ds_state_e       state_q;
    logic [WDW-1:0]  wd_q;
    logic            bypass_q;
    logic            out_valid_q;
    logic [SIZE-1:0] out_entry_q;
    logic [RW-1:0]   out_result_q;
    logic            out_err_q;

    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [SIZE-1:0] fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            launch_go;
    logic            bypass_c;

    entry_fifo #(.WIDTH(SIZE), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (io.in_entry),
        .pop       (launch_go),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign io.in_ready = !fifo_full;
    assign fifo_push   = io.in_valid && !fifo_full;
    assign busy        = (state_q != DS_IDLE) || (fifo_count != '0);

    // Head is popped on the edge that enters LAUNCH, so eng_entry is valid for the whole job.
    assign launch_go = !fifo_empty &&
                       ((state_q == DS_IDLE) || ((state_q == DS_OUT) && io.out_ready));

`ifdef ENTRY_DISPATCHER_BYPASS_EN
    assign bypass_c = (fifo_head < SIZE'(2));
`else
    assign bypass_c = 1'b0;
`endif

    assign io.out_valid  = out_valid_q;
    assign io.out_entry  = out_entry_q;
    assign io.out_result = out_result_q;
    assign io.out_err    = out_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DS_IDLE;
            wd_q         <= '0;
            bypass_q     <= 1'b0;
            eng_load     <= 1'b0;
            eng_mask     <= 1'b0;
            eng_entry    <= '0;
            out_valid_q  <= 1'b0;
            out_entry_q  <= '0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            eng_load <= 1'b0;
            if (launch_go) begin
                state_q     <= DS_LAUNCH;
                eng_entry   <= fifo_head;
                eng_load    <= !bypass_c;
                eng_mask    <= 1'b1;
                bypass_q    <= bypass_c;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    DS_LAUNCH: begin
                        if (bypass_q) begin
                            state_q      <= DS_OUT;
                            eng_mask     <= 1'b0;
                            out_valid_q  <= 1'b1;
                            out_entry_q  <= eng_entry;
                            out_result_q <= RW'(1);
                            out_err_q    <= 1'b0;
                        end else begin
                            state_q <= DS_GUARD;
                        end
                    end
                    DS_GUARD: begin
                        state_q  <= DS_WAIT;
                        eng_mask <= 1'b0;
                        wd_q     <= '0;
                    end
                    // Completion beats a timeout that expires in the same cycle.
                    DS_WAIT: begin
                        if (eng_done) begin
                            state_q      <= DS_OUT;
                            out_valid_q  <= 1'b1;
                            out_entry_q  <= eng_entry;
                            out_result_q <= eng_result;
                            out_err_q    <= 1'b0;
                        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                            state_q      <= DS_OUT;
                            out_valid_q  <= 1'b1;
                            out_entry_q  <= eng_entry;
                            out_result_q <= '0;
                            out_err_q    <= 1'b1;
                        end else begin
                            wd_q <= wd_q + WDW'(1);
                        end
                    end
                    DS_OUT: begin
                        if (io.out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= DS_IDLE;
                        end
                    end
                    default: state_q <= DS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_entry_dispatcher.sv
// Scoreboard bench for entry_dispatcher with a behavioural engine stub.
module tb_entry_dispatcher;
    import recur_pkg::*;

    localparam int unsigned SIZE    = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned RW      = result_width(SIZE);

    typedef struct {
        logic [SIZE-1:0] entry;
        logic [RW-1:0]   result;
        logic            err;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            eng_load;
    logic [SIZE-1:0] eng_entry;
    logic            eng_mask;
    logic            eng_done;
    logic [RW-1:0]   eng_result;
    logic            busy;

    entry_dispatcher_if #(.SIZE(SIZE)) io ();

    entry_dispatcher #(.SIZE(SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .eng_load   (eng_load),
        .eng_entry  (eng_entry),
        .eng_mask   (eng_mask),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          eng_delay = 0;
    bit          eng_hold  = 0;
    logic [RW-1:0] hold_val = '0;
    int          load_cnt  = 0;
    int          mask_cnt  = 0;
    exp_t        exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine stand-in: result is n*19+2, mod 256
    function automatic logic [RW-1:0] f_model(input logic [SIZE-1:0] n);
        return RW'(32'(n) * 19 + 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Engine stub: a load starts a countdown of eng_delay (0 = never finish); done lasts one cycle.
    initial begin
        int cnt;
        logic [SIZE-1:0] job;
        cnt = 0;
        job = '0;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(negedge clk);
            if (eng_load) load_cnt++;
            if (eng_mask) mask_cnt++;
            if (eng_hold) begin
                eng_done   = 1'b1;
                eng_result = hold_val;
            end else begin
                eng_done = 1'b0;
                if (eng_load) begin
                    cnt = eng_delay;
                    job = eng_entry;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_done   = 1'b1;
                        eng_result = f_model(job);
                    end
                end
            end
        end
    end

    // Monitor: every accepted output is compared against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got entry 0x%0h result 0x%0h, required no output",
                             io.out_entry, io.out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("out_entry",  32'(io.out_entry),  32'(e.entry));
                    check("out_result", 32'(io.out_result), 32'(e.result));
                    check("out_err",    32'(io.out_err),    32'(e.err));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(io.in_ready),   32'd1);
        check({tag, "_eng_load"},   32'(eng_load),      32'd0);
        check({tag, "_eng_mask"},   32'(eng_mask),      32'd0);
        check({tag, "_eng_entry"},  32'(eng_entry),     32'd0);
        check({tag, "_out_valid"},  32'(io.out_valid),  32'd0);
        check({tag, "_out_entry"},  32'(io.out_entry),  32'd0);
        check({tag, "_out_result"}, 32'(io.out_result), 32'd0);
        check({tag, "_out_err"},    32'(io.out_err),    32'd0);
        check({tag, "_busy"},       32'(busy),          32'd0);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic push(input logic [SIZE-1:0] e, input logic [RW-1:0] res, input logic err,
                        input bit enq);
        int t;
        exp_t x;
        t = 0;
        io.in_valid = 1'b1;
        io.in_entry = e;
        while (!io.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_stalled", 32'(t), 32'd0);
        if (enq) begin
            x.entry  = e;
            x.result = res;
            x.err    = err;
            exp_q.push_back(x);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(t < 500), 32'd1);
    endtask

    task automatic wait_valid(inout int cyc);
        while (!io.out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time bound");
        $fatal(1);
    end

    initial begin
        int cyc;
        int base;
        bit stall_ok;

        rst = 1'b1;
        io.in_valid  = 1'b0;
        io.in_entry  = '0;
        io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Single job: done 10 cycles into WAIT
        io.out_ready = 1'b1;
        eng_delay = 11;
        load_cnt = 0;
        mask_cnt = 0;
        push(4'd5, 8'h61, 1'b0, 1'b1);
        cyc = 0;
        check("t1_idle_no_load", 32'(eng_load), 32'd0);
        @(negedge clk);
        cyc = 1;
        check("t1_load_high",  32'(eng_load),  32'd1);
        check("t1_eng_entry",  32'(eng_entry), 32'd5);
        check("t1_mask_high",  32'(eng_mask),  32'd1);
        wait_valid(cyc);
        check("t1_latency", 32'(cyc), 32'd13);
        check("t1_eng_entry_hold", 32'(eng_entry), 32'd5);
        drain("t1");
        check("t1_load_pulses", 32'(load_cnt), 32'd1);
        check("t1_mask_cycles", 32'(mask_cnt), 32'd2);

        // Backpressure: job 6 parked in OUT, then fill the FIFO behind it
        io.out_ready = 1'b0;
        eng_delay = 3;
        push(4'd6, f_model(4'd6), 1'b0, 1'b1);
        cyc = 0;
        wait_valid(cyc);
        check("t2_first_valid", 32'(io.out_valid), 32'd1);
        for (int i = 7; i <= 10; i++) push(SIZE'(i), f_model(SIZE'(i)), 1'b0, 1'b1);
        check("t2_full_in_ready", 32'(io.in_ready), 32'd0);
        io.in_valid = 1'b1;
        io.in_entry = 4'd11;
        begin
            exp_t x;
            x.entry = 4'd11; x.result = f_model(4'd11); x.err = 1'b0;
            exp_q.push_back(x);
        end
        stall_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (io.in_ready) stall_ok = 1'b0;
        end
        check("t2_stalled", 32'(stall_ok), 32'd1);
        @(negedge clk);
        io.out_ready = 1'b1;
        check("t2_no_pop_credit", 32'(io.in_ready), 32'd0);
        @(negedge clk);
        check("t2_in_ready_rise", 32'(io.in_ready), 32'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
        drain("t2");

        // eng_done held high from before launch: only the first WAIT sample counts
        hold_val = f_model(4'd12);
        eng_hold = 1'b1;
        base = load_cnt;
        @(negedge clk);
        push(4'd12, f_model(4'd12), 1'b0, 1'b1);
        cyc = 0;
        wait_valid(cyc);
        check("t3_latency", 32'(cyc), 32'd4);
        eng_hold = 1'b0;
        drain("t3");
        check("t3_load_pulses", 32'(load_cnt - base), 32'd1);

        // Timeout on 13, then 14 launches straight from OUT
        eng_delay = 0;
        push(4'd13, '0, 1'b1, 1'b1);
        cyc = 0;
        push(4'd14, f_model(4'd14), 1'b0, 1'b1);
        cyc = 1;
        @(negedge clk);
        cyc = 2;
        eng_delay = 4;
        wait_valid(cyc);
        check("t4_timeout_latency", 32'(cyc), 32'd19);
        check("t4_err", 32'(io.out_err), 32'd1);
        @(negedge clk);
        check("t4_next_load", 32'(eng_load), 32'd1);
        check("t4_next_entry", 32'(eng_entry), 32'd14);
        drain("t4");

        // Reset while in WAIT with two entries queued
        eng_delay = 0;
        push(4'd3, '0, 1'b0, 1'b0);
        push(4'd4, '0, 1'b0, 1'b0);
        push(4'd5, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        check("t5_entry_before", 32'(eng_entry), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async");
        @(negedge clk);
        rst = 1'b0;
        base = load_cnt;
        repeat (10) @(negedge clk);
        check("t5_no_load_after", 32'(load_cnt - base), 32'd0);
        check("t5_idle_after", 32'(busy), 32'd0);

        // Entry 1: bypassed when enabled, otherwise a normal engine job
        base = load_cnt;
`ifdef ENTRY_DISPATCHER_BYPASS_EN
        push(4'd1, RW'(1), 1'b0, 1'b1);
        cyc = 0;
        wait_valid(cyc);
        check("t6_bypass_latency", 32'(cyc), 32'd2);
        drain("t6");
        check("t6_bypass_loads", 32'(load_cnt - base), 32'd0);
`else
        eng_delay = 3;
        push(4'd1, f_model(4'd1), 1'b0, 1'b1);
        cyc = 0;
        wait_valid(cyc);
        check("t6_engine_latency", 32'(cyc), 32'd5);
        drain("t6");
        check("t6_engine_loads", 32'(load_cnt - base), 32'd1);
`endif

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
